// File: rtl/pico_arb_2_1_if.sv
// -----------------------------------------------------------------------------
// pico_arb_2_1_if
// One PicoRV32-style native memory bus link (request + completion).
//
// Signals:
//   valid  request strobe, held until ready or abandoned by the master
//   addr   32-bit byte address
//   wdata  32-bit write data
//   wstrb  4-bit byte strobes, 4'b0000 means read
//   ready  one-cycle completion from the responder
//   rdata  32-bit read data, meaningful while ready=1
//
// Modports:
//   master  drives the request, receives the completion
//   slave   receives the request, drives the completion
// -----------------------------------------------------------------------------
interface pico_arb_2_1_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/pico_arb_2_1.sv
// -----------------------------------------------------------------------------
// pico_arb_2_1
// Two-master, one-slave round-robin arbiter for the PicoRV32 native bus, with
// a watchdog that answers a stalled transfer with an error read value.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without slave ready before the error response
//                   is issued; 0 disables the watchdog
//   ERR_RDATA       rdata handed to the master on a timeout
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   picom0         master 0 link (arbiter is the responder)
//   picom1         master 1 link (arbiter is the responder)
//   picos          shared slave link (arbiter is the requester)
//   timeout_pulse  one-cycle pulse in the cycle the error response is issued
// -----------------------------------------------------------------------------
module pico_arb_2_1 #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    pico_arb_2_1_if.slave         picom0,
    pico_arb_2_1_if.slave         picom1,
    pico_arb_2_1_if.master        picos,
    output logic                  timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        last_grant, last_grant_nx;
    logic [15:0] cnt, cnt_nx;

    // Request of the master owning the slave; only meaningful in BUSYk.
    logic        sel_m1;
    logic        sel_valid;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    // Completion to be routed back to the owning master.
    logic        resp_ready;
    logic [31:0] resp_rdata;

    assign sel_m1    = (state == BUSY1);
    assign sel_valid = sel_m1 ? picom1.valid : picom0.valid;
    assign sel_addr  = sel_m1 ? picom1.addr  : picom0.addr;
    assign sel_wdata = sel_m1 ? picom1.wdata : picom0.wdata;
    assign sel_wstrb = sel_m1 ? picom1.wstrb : picom0.wstrb;

    always_comb begin
        // NOTE: every output and next-state value gets a default before the
        // case so no path through this block can infer a latch.
        state_nx      = state;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        resp_ready    = 1'b0;
        resp_rdata    = 32'h0;
        picos.valid   = 1'b0;
        picos.addr    = 32'h0;
        picos.wdata   = 32'h0;
        picos.wstrb   = 4'h0;
        picom0.ready  = 1'b0;
        picom0.rdata  = 32'h0;
        picom1.ready  = 1'b0;
        picom1.rdata  = 32'h0;
        timeout_pulse = 1'b0;

        case (state)
            IDLE: begin
                // Slave ready is ignored here; the counter is cleared so the
                // next BUSY state starts counting from zero.
                cnt_nx = 16'h0;
                if (picom0.valid && picom1.valid) begin
                    state_nx = last_grant ? BUSY0 : BUSY1;
                end else if (picom0.valid) begin
                    state_nx = BUSY0;
                end else if (picom1.valid) begin
                    state_nx = BUSY1;
                end
            end

            BUSY0, BUSY1: begin
                picos.valid = sel_valid;
                picos.addr  = sel_addr;
                picos.wdata = sel_wdata;
                picos.wstrb = sel_wstrb;
                resp_ready  = picos.ready;
                resp_rdata  = picos.rdata;

                if (!sel_valid) begin
                    // Master abandoned the request: drop it silently and keep
                    // the round-robin history as it was.
                    resp_ready = 1'b0;
                    resp_rdata = 32'h0;
                    state_nx   = IDLE;
                end else if (picos.ready) begin
                    // A real completion beats a coincident timeout.
                    state_nx      = IDLE;
                    last_grant_nx = sel_m1;
                end else if ((TIMEOUT_CYCLES != 16'd0) && (cnt == TIMEOUT_CYCLES)) begin
                    picos.valid   = 1'b0;
                    resp_ready    = 1'b1;
                    resp_rdata    = ERR_RDATA;
                    timeout_pulse = 1'b1;
                    state_nx      = IDLE;
                    last_grant_nx = sel_m1;
                end else if (cnt != 16'hFFFF) begin
                    cnt_nx = cnt + 16'd1;
                end

                if (sel_m1) begin
                    picom1.ready = resp_ready;
                    picom1.rdata = resp_rdata;
                end else begin
                    picom0.ready = resp_ready;
                    picom0.rdata = resp_rdata;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;  // master 0 wins the first tie
            cnt        <= 16'h0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_pico_arb_2_1.sv
// -----------------------------------------------------------------------------
// tb_pico_arb_2_1
// Self-checking bench for pico_arb_2_1 (TIMEOUT_CYCLES=4). Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge. Expected
// master completions are queued when a transfer is launched and popped by a
// monitor whenever either master sees ready.
// -----------------------------------------------------------------------------
module tb_pico_arb_2_1;

    logic clk = 1'b0;
    logic rst;
    logic timeout_pulse;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        m;
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    exp_t sb[$];

    pico_arb_2_1_if m0_if ();
    pico_arb_2_1_if m1_if ();
    pico_arb_2_1_if s_if ();

    pico_arb_2_1 #(
        .TIMEOUT_CYCLES (16'd4),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .picom0        (m0_if),
        .picom1        (m1_if),
        .picos         (s_if),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    // Response monitor / scoreboard.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        got_m;
        logic [31:0] got_rd;
        if (rst === 1'b0) begin
            if (m0_if.ready === 1'b1 || m1_if.ready === 1'b1) begin
                total++;
                got_m  = (m1_if.ready === 1'b1);
                got_rd = got_m ? m1_if.rdata : m0_if.rdata;
                if (m0_if.ready === 1'b1 && m1_if.ready === 1'b1) begin
                    bad++;
                    $display("FAIL both_ready: both masters saw ready at %0t", $time);
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready: master %0d rdata=%h, none expected", got_m, got_rd);
                end else begin
                    e = sb.pop_front();
                    if (got_m !== e.m || got_rd !== e.rdata || timeout_pulse !== e.to) begin
                        bad++;
                        $display("FAIL response: got m=%0d rdata=%h to=%b, want m=%0d rdata=%h to=%b",
                                 got_m, got_rd, timeout_pulse, e.m, e.rdata, e.to);
                    end
                end
            end else if (timeout_pulse !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL stray_timeout: timeout_pulse=%b with no ready", timeout_pulse);
            end
        end
    end

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit m, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (m) begin
            m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
        end else begin
            m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_m(0, 1'b1, 32'h0000_0100, 32'h1, 4'hF);
        set_m(1, 1'b1, 32'h0000_0200, 32'h2, 4'hF);
        s_if.ready = 1'b1;
        s_if.rdata = 32'h5555_5555;
        drive_point();
        drive_point();
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b0 || s_if.addr !== 32'h0 || s_if.wdata !== 32'h0 || s_if.wstrb !== 4'h0) begin
            bad++;
            $display("FAIL reset_slave_side: valid=%b addr=%h wdata=%h wstrb=%h, want all 0",
                     s_if.valid, s_if.addr, s_if.wdata, s_if.wstrb);
        end
        total++;
        if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0 || m0_if.rdata !== 32'h0 ||
            m1_if.rdata !== 32'h0 || timeout_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_master_side: r0=%b r1=%b d0=%h d1=%h to=%b, want all 0",
                     m0_if.ready, m1_if.ready, m0_if.rdata, m1_if.rdata, timeout_pulse);
        end
        drive_point();
        rst = 1'b0;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: picos_valid=%b, want 0", s_if.valid);
        end
    endtask

    task automatic test_idle_ready_ignored();
        drive_point();
        s_if.ready = 1'b1;
        s_if.rdata = 32'hFFFF_0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0 || s_if.valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_ready_ignored: r0=%b r1=%b picos_valid=%b, want 0 0 0",
                         m0_if.ready, m1_if.ready, s_if.valid);
            end
            drive_point();
        end
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
    endtask

    task automatic test_single_transfers();
        bit          tm [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ta [3] = '{32'h0000_1000, 32'h4000_0010, 32'h0000_2004};
        logic [31:0] td [3] = '{32'h0, 32'hA5A5_A5A5, 32'h0};
        logic [3:0]  tw [3] = '{4'b0000, 4'b0011, 4'b0000};
        int          tl [3] = '{2, 3, 0};
        logic [31:0] tr [3] = '{32'h1234_5678, 32'h0000_0000, 32'hCAFE_0001};
        logic        other;
        for (int i = 0; i < 3; i++) begin
            drive_point();
            set_m(tm[i], 1'b1, ta[i], td[i], tw[i]);
            sb.push_back('{m: tm[i], rdata: tr[i], to: 1'b0});
            @(negedge clk);
            total++;
            if (s_if.valid !== 1'b0) begin
                bad++;
                $display("FAIL arb_latency[%0d]: picos_valid=%b in request cycle, want 0", i, s_if.valid);
            end
            for (int c = 0; c <= tl[i]; c++) begin
                drive_point();
                if (c == tl[i]) begin
                    s_if.ready = 1'b1;
                    s_if.rdata = tr[i];
                end
                @(negedge clk);
                total++;
                if (s_if.valid !== 1'b1 || s_if.addr !== ta[i] || s_if.wdata !== td[i] || s_if.wstrb !== tw[i]) begin
                    bad++;
                    $display("FAIL forward[%0d] c=%0d: got v=%b a=%h d=%h s=%h, want v=1 a=%h d=%h s=%h",
                             i, c, s_if.valid, s_if.addr, s_if.wdata, s_if.wstrb, ta[i], td[i], tw[i]);
                end
                other = tm[i] ? m0_if.ready : m1_if.ready;
                total++;
                if (other !== 1'b0) begin
                    bad++;
                    $display("FAIL other_ready[%0d] c=%0d: other master ready=%b, want 0", i, c, other);
                end
            end
            drive_point();
            set_m(tm[i], 1'b0, 32'h0, 32'h0, 4'h0);
            s_if.ready = 1'b0;
            s_if.rdata = 32'h0;
            @(negedge clk);
            total++;
            if (s_if.valid !== 1'b0 || m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) begin
                bad++;
                $display("FAIL idle_gap[%0d]: picos_valid=%b r0=%b r1=%b, want 0 0 0",
                         i, s_if.valid, m0_if.ready, m1_if.ready);
            end
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL missing_response[%0d]: %0d pending, want 0", i, sb.size());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] want_addr [3] = '{32'h0000_A000, 32'h0000_B000, 32'h0000_A004};
        drive_point();
        rst = 1'b1;
        drive_point();
        rst = 1'b0;
        set_m(0, 1'b1, 32'h0000_A000, 32'h0, 4'h0);
        set_m(1, 1'b1, 32'h0000_B000, 32'h0, 4'h0);
        sb.push_back('{m: 1'b0, rdata: 32'h0000_0A0A, to: 1'b0});
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            total++;
            if (s_if.valid !== 1'b0) begin
                bad++;
                $display("FAIL rr_idle[%0d]: picos_valid=%b, want 0", g, s_if.valid);
            end
            drive_point();
            s_if.ready = 1'b1;
            s_if.rdata = (g == 1) ? 32'h0000_0B0B : ((g == 0) ? 32'h0000_0A0A : 32'h0000_0A44);
            @(negedge clk);
            total++;
            if (s_if.valid !== 1'b1 || s_if.addr !== want_addr[g]) begin
                bad++;
                $display("FAIL rr_grant[%0d]: picos_valid=%b addr=%h, want 1 %h",
                         g, s_if.valid, s_if.addr, want_addr[g]);
            end
            drive_point();
            s_if.ready = 1'b0;
            s_if.rdata = 32'h0;
            if (g == 0) begin
                set_m(0, 1'b1, 32'h0000_A004, 32'h0, 4'h0);
                sb.push_back('{m: 1'b1, rdata: 32'h0000_0B0B, to: 1'b0});
            end else if (g == 1) begin
                set_m(1, 1'b1, 32'h0000_B004, 32'h0, 4'h0);
                sb.push_back('{m: 1'b0, rdata: 32'h0000_0A44, to: 1'b0});
            end else begin
                set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
                set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
            end
        end
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rr_missing: %0d pending, want 0", sb.size());
        end
    endtask

    task automatic test_abort();
        // Last completion was master 0, so after master 1 aborts the next tie
        // must still go to master 1.
        drive_point();
        set_m(1, 1'b1, 32'h0000_C000, 32'h0, 4'h0);
        @(negedge clk);
        drive_point();
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b1 || s_if.addr !== 32'h0000_C000) begin
            bad++;
            $display("FAIL abort_busy: picos_valid=%b addr=%h, want 1 0000c000", s_if.valid, s_if.addr);
        end
        drive_point();
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b1;
        s_if.rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b0 || m1_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_drop: picos_valid=%b r1=%b, want 0 0", s_if.valid, m1_if.ready);
        end
        drive_point();
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        set_m(0, 1'b1, 32'h0000_D000, 32'h0, 4'h0);
        set_m(1, 1'b1, 32'h0000_E000, 32'h0, 4'h0);
        sb.push_back('{m: 1'b1, rdata: 32'h0000_0E0E, to: 1'b0});
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: picos_valid=%b, want 0", s_if.valid);
        end
        drive_point();
        s_if.ready = 1'b1;
        s_if.rdata = 32'h0000_0E0E;
        @(negedge clk);
        total++;
        if (s_if.addr !== 32'h0000_E000) begin
            bad++;
            $display("FAIL abort_history: picos_addr=%h, want 0000e000", s_if.addr);
        end
        drive_point();
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL abort_missing: %0d pending, want 0", sb.size());
        end
    endtask

    // race=0: slave never answers, error response in the 5th BUSY cycle.
    // race=1: slave answers in that same cycle and wins.
    task automatic test_timeout(input bit race);
        logic [31:0] rd;
        rd = race ? 32'h600D_CAFE : 32'hDEAD_BEEF;
        drive_point();
        set_m(0, 1'b1, 32'h0000_3000, 32'h0, 4'h0);
        sb.push_back('{m: 1'b0, rdata: rd, to: !race});
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            drive_point();
            if (race && c == 4) begin
                s_if.ready = 1'b1;
                s_if.rdata = 32'h600D_CAFE;
            end
            @(negedge clk);
            total++;
            if (c < 4 || race) begin
                if (s_if.valid !== 1'b1 || timeout_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_wait[race=%0d c=%0d]: picos_valid=%b to=%b, want 1 0",
                             race, c, s_if.valid, timeout_pulse);
                end
            end else begin
                if (s_if.valid !== 1'b0 || timeout_pulse !== 1'b1 || m0_if.ready !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_fire: picos_valid=%b to=%b r0=%b, want 0 1 1",
                             s_if.valid, timeout_pulse, m0_if.ready);
                end
            end
        end
        drive_point();
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b0 || timeout_pulse !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL timeout_after[race=%0d]: picos_valid=%b to=%b pending=%0d, want 0 0 0",
                     race, s_if.valid, timeout_pulse, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        // Previous completion was master 0; reset must restore master 0
        // priority for the next tie.
        drive_point();
        set_m(0, 1'b1, 32'h0000_5000, 32'h0, 4'h0);
        @(negedge clk);
        drive_point();
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy: picos_valid=%b, want 1", s_if.valid);
        end
        drive_point();
        rst = 1'b1;
        @(negedge clk);
        drive_point();
        rst = 1'b0;
        set_m(1, 1'b1, 32'h0000_6000, 32'h0, 4'h0);
        @(negedge clk);
        total++;
        if (s_if.valid !== 1'b0 || m0_if.ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_abandon: picos_valid=%b r0=%b, want 0 0", s_if.valid, m0_if.ready);
        end
        sb.push_back('{m: 1'b0, rdata: 32'h0000_5050, to: 1'b0});
        drive_point();
        s_if.ready = 1'b1;
        s_if.rdata = 32'h0000_5050;
        @(negedge clk);
        total++;
        if (s_if.addr !== 32'h0000_5000) begin
            bad++;
            $display("FAIL rstmid_tie: picos_addr=%h, want 00005000", s_if.addr);
        end
        drive_point();
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rstmid_missing: %0d pending, want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;

        test_reset();
        test_idle_ready_ignored();
        test_single_transfers();
        test_round_robin();
        test_abort();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pico_arb_2_1.md
PICO_ARB_2_1 -- requirements
Module: pico_arb_2_1

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd255, max BUSY cycles without picos_ready before an error response; 0 disables timeout.
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, rdata returned to the master on timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 picom0_valid / picom1_valid  input  1  master 0/1 request.
REQ-006 picom0_addr / picom1_addr  input  32  master 0/1 address.
REQ-007 picom0_wdata / picom1_wdata  input  32  master 0/1 write data.
REQ-008 picom0_wstrb / picom1_wstrb  input  4  master 0/1 byte strobes; 0 = read.
REQ-009 picom0_ready / picom1_ready  output  1  completion to master 0/1.
REQ-010 picom0_rdata / picom1_rdata  output  32  read data to master 0/1.
REQ-011 picos_valid  output  1  request to shared slave.
REQ-012 picos_addr / picos_wdata / picos_wstrb  output  32/32/4  forwarded from granted master.
REQ-013 picos_ready  input  1  slave completion.
REQ-014 picos_rdata  input  32  slave read data.
REQ-015 timeout_pulse  output  1  one-cycle pulse when a timeout error response is issued.

Function
REQ-016 The block SHALL implement FSM states IDLE, BUSY0, BUSY1, plus a 1-bit last_grant register and a 16-bit cycle counter cnt.
REQ-017 IDLE: picos_valid=0, picos_addr/wdata/wstrb=0, both picomN_ready=0, both picomN_rdata=0.
REQ-018 IDLE, only master k valid -> next state BUSYk; arbitration latency exactly 1 cycle (valid sampled in IDLE, slave sees request the following cycle).
REQ-019 IDLE, both valid -> grant master != last_grant (round robin).
REQ-020 On entering BUSYk: cnt=0.
REQ-021 BUSYk: picos_valid=picomk_valid; picos_addr/wdata/wstrb = master k's signals combinationally.
REQ-022 BUSYk: picomk_ready=picos_ready, picomk_rdata=picos_rdata combinationally; the other master's ready=0, rdata=0.
REQ-023 BUSYk with picos_ready=1 -> next state IDLE, last_grant=k.
REQ-024 BUSYk, picos_ready=0, cnt<TIMEOUT_CYCLES (or TIMEOUT_CYCLES=0) -> stay, cnt=cnt+1 saturating at 16'hFFFF.
REQ-025 BUSYk, picos_ready=0, TIMEOUT_CYCLES!=0, cnt==TIMEOUT_CYCLES -> that cycle: picos_valid=0, picomk_ready=1, picomk_rdata=ERR_RDATA, timeout_pulse=1; next state IDLE, last_grant=k.
REQ-026 picos_ready=1 in the timeout cycle: normal completion wins; no error, timeout_pulse=0.
REQ-027 BUSYk with picomk_valid=0 (master abort) -> picos_valid=0, next state IDLE, last_grant unchanged, no ready issued.
REQ-028 After every completion one IDLE cycle SHALL separate transactions (no back-to-back grant).
REQ-029 picos_ready while in IDLE SHALL be ignored.
REQ-030 timeout_pulse=0 in all cycles except per REQ-025.

Reset
REQ-031 rst=1 at a clock edge -> state=IDLE, last_grant=1 (master 0 wins the first tie), cnt=0; outputs per REQ-017, timeout_pulse=0.
REQ-032 Reset mid-transaction SHALL abandon it without issuing ready to either master; outputs at IDLE values from the cycle after the reset edge.

Verification
REQ-033 Master 0 read 0x0000_1000, slave ready 2 cycles after picos_valid with rdata 0x1234_5678 -> picom0_ready=1 with rdata 0x1234_5678 for one cycle, picom1_ready stays 0.
REQ-034 Both valid after reset -> master 0 granted first; on simultaneous re-request master 1 granted next; picos_addr tracks the granted master.
REQ-035 Master 1 write addr 0x4000_0010, wdata 0xA5A5_A5A5, wstrb 4'b0011 -> picos_* carry exactly these values while BUSY1.
REQ-036 TIMEOUT_CYCLES=4, slave never ready -> picom0_ready=1, rdata=0xDEAD_BEEF, timeout_pulse=1 in the 5th BUSY0 cycle; then IDLE.
REQ-037 TIMEOUT_CYCLES=4, picos_ready asserted in the 5th BUSY cycle -> normal rdata returned, timeout_pulse=0.
REQ-038 rst asserted in BUSY0 -> next cycle picos_valid=0, no picom0_ready pulse, next tie grants master 0.
